rectifier_deadtime: RTL and testbench
=====================================

# rectifier_deadtime

Downstream stage of the grid-side rectifier switching-pattern generator. It takes the six raw per-switch commands (Sap..Scn) and produces six registered gate-drive signals. It inserts a programmable dead time on every turn-on and blocks shoot-through on each of the three legs. Its outputs go directly to the gate-driver pins.

## Interface
Parameters:
- DT_CYCLES, 100, dead-time length in sysclk cycles; legal range 1..255.
- DT_W, 8, dead-time counter width; must satisfy DT_CYCLES < 2**DT_W.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- global_rst  in  1  reset. Synchronous, active-low.
- SD  in  1  shutdown; low forces all gates off.
- Sap, San, Sbp, Sbn, Scp, Scn  in  1 each  raw switch commands, synchronous to sysclk.
- fault_clr  in  1  clears latched leg faults (meaningful only with the fault latch).
- Gap, Gan, Gbp, Gbn, Gcp, Gcn  out  1 each  gate drives, registered.
- fault  out  3  per-leg shoot-through flag; bit 0 = leg a, bit 1 = leg b, bit 2 = leg c.

## Operation
- There are three identical, independent leg controllers (a, b, c). Each leg has a request `req` decoded from its pair (p, n):
  - 00 = NONE
  - 10 = P
  - 01 = N
  - 11 = BOTH (illegal)
- Each leg FSM has the states OFF, DEAD, P_ON, N_ON. A DEAD state holds a target (P or N) and a counter.
- In **OFF** (both gates 0):
  - req P or N → DEAD with target = req and cnt = DT_CYCLES-1.
  - req NONE or BOTH → stay in OFF.
- In **DEAD** (both gates 0):
  - req == target and cnt == 0 → P_ON or N_ON.
  - req == target and cnt != 0 → cnt decrements.
  - req is the opposite side → reload cnt = DT_CYCLES-1 and set target = req.
  - req NONE or BOTH → OFF.
- In **P_ON** (Gxp = 1, Gxn = 0):
  - req P → stay.
  - req N → DEAD with target N and cnt reloaded.
  - req NONE or BOTH → OFF.
- **N_ON** is symmetric to P_ON.
- The two gates of a leg are never high together in any state. The gate outputs are decoded from the next state and registered.
- **BOTH** request: the leg is forced to OFF and the corresponding fault bit is raised (see Configuration).
- **SD low**: has priority over everything except reset.
  - At the next edge all FSMs go to OFF, all gates go to 0, and counters clear.
  - Fault state is unaffected.
  - When SD returns high, every turn-on again requires the full dead time.
- **Reset** (global_rst low at an edge):
  - All gates 0, fault = 3'b000, all FSMs OFF, counters 0.
  - Takes effect from any state, including mid-DEAD.

## Timing
- Turn-on: request first sampled at edge k → gate high after edge k+DT_CYCLES. With DT_CYCLES = 1, the gate is high after edge k+1.
- Turn-off: request removed at edge k → gate low after edge k (one registered cycle).
- Commutation P→N: Gxp low after edge k, Gxn high after edge k+DT_CYCLES. The gap with both gates low is exactly DT_CYCLES cycles.
- A request glitch shorter than DT_CYCLES never produces a gate pulse.
- Simultaneous SD low and a new request: SD wins.
- Simultaneous fault_clr and a BOTH request: the fault stays set.

## Configuration
- Macro: RECT_DT_FAULT_LATCH_EN.
- **Defined:**
  - A BOTH request sets fault[i] sticky.
  - While fault[i] = 1, leg i stays in OFF regardless of its request.
  - fault_clr high at an edge clears all fault bits whose legs do not currently request BOTH.
- **Undefined:**
  - fault[i] is a registered copy of (req == BOTH), high for exactly the cycles following a BOTH sample.
  - Once the request becomes legal, the leg resumes normal operation, starting with a full dead time.
  - fault_clr is ignored.

## Structure
- Shared package rect_pkg holds:
  - the leg-state enum (OFF, DEAD, P_ON, N_ON);
  - the request encoding (NONE, P, N, BOTH);
  - the default dead-time constant RECT_DT_DEFAULT = 100.
- Sub-module dt_leg: one FSM, counter and fault bit. It is instantiated three times by rectifier_deadtime with identical parameters.
- The top level contains only the SD/reset fan-out and the port mapping.

## Test plan
- Reset and shutdown:
  - Hold global_rst low for 3 cycles with Sap = 1 → all G* = 0 and fault = 0.
  - Release reset with SD = 1 and DT_CYCLES = 4 → Gap rises after edge k+4.
- Commutation: DT_CYCLES = 4, leg a switches from Sap = 1 to San = 1 at edge k.
  - Gap falls after edge k.
  - Gan rises after edge k+4.
  - Gap & Gan is never 1.
- Glitch rejection: DT_CYCLES = 4, Sbp = 1 for 3 cycles then 0 → Gbp stays 0 throughout.
- SD during DEAD: DT_CYCLES = 10, SD pulled low at cycle 5 of a dead time.
  - All gates stay 0.
  - After SD returns high, Gcp rises a full 10 cycles later.
- Shoot-through request: Scp = Scn = 1 for 2 cycles, then Scp = 1.
  - With the macro: fault = 3'b100 sticky and Gcp stays 0 until fault_clr, then Gcp rises DT_CYCLES later.
  - Without the macro: fault[2] is high for 2 cycles and Gcp rises DT_CYCLES after the request becomes legal.
- Independence: legs a, b, c are driven with staggered sector patterns from the switching-pattern generator. Each leg's dead time is unaffected by activity on the other legs.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared types and constants for the rectifier dead-time stage: leg FSM states,
// the per-leg request encoding {p, n} and the default dead-time length.
package rect_pkg;

  localparam int RECT_DT_DEFAULT = 100;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_P_ON = 2'd2,
    ST_N_ON = 2'd3
  } leg_state_t;

  // Encoding is the raw {p, n} pair so a request decodes with a plain cast.
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_N    = 2'b01,
    REQ_P    = 2'b10,
    REQ_BOTH = 2'b11
  } leg_req_t;

  function automatic leg_req_t decode_req(input logic p, input logic n);
    return leg_req_t'({p, n});
  endfunction

endpackage

// File: rtl/rectifier_deadtime_if.sv
// One half-bridge leg: raw switch command pair in, registered gate pair out.
// master drives the commands, slave (the leg controller) drives the gates.
interface rectifier_deadtime_if;
  logic p;
  logic n;
  logic gp;
  logic gn;

  modport master (output p, output n, input gp, input gn);
  modport slave  (input p, input n, output gp, output gn);
endinterface

// File: rtl/dt_leg.sv
// Single-leg dead-time controller: OFF/DEAD/P_ON/N_ON FSM, reload counter and
// shoot-through flag. RECT_DT_FAULT_LATCH_EN makes the flag sticky until cleared.
module dt_leg
  import rect_pkg::*;
#(
  parameter int DT_CYCLES = RECT_DT_DEFAULT,
  parameter int DT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sd,
  input  logic                  fault_clr,
  rectifier_deadtime_if.slave   leg,
  output logic                  fault
);

  localparam logic [DT_W-1:0] DT_RELOAD = DT_W'(DT_CYCLES - 1);

  leg_state_t      state_q, state_d;
  leg_req_t        target_q, target_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;
  logic            gp_q, gn_q;
  leg_req_t        req;
  logic            both;
  logic            blocked;

  assign req  = decode_req(leg.p, leg.n);
  assign both = (req == REQ_BOTH);

`ifdef RECT_DT_FAULT_LATCH_EN
  // A sticky fault holds the leg off; a BOTH request re-arms it even while clearing.
  assign blocked = both | fault_q;
  assign fault_d = both | (fault_q & ~fault_clr);
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign blocked = both;
  assign fault_d = both;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no latch is inferred.
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (!sd || blocked) begin
      state_d  = ST_OFF;
      target_d = REQ_NONE;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (req == REQ_P || req == REQ_N) begin
            state_d  = ST_DEAD;
            target_d = req;
            cnt_d    = DT_RELOAD;
          end
        end
        ST_DEAD: begin
          if (req == REQ_NONE) begin
            state_d  = ST_OFF;
            target_d = REQ_NONE;
            cnt_d    = '0;
          end else if (req == target_q) begin
            if (cnt_q == '0) state_d = (target_q == REQ_P) ? ST_P_ON : ST_N_ON;
            else             cnt_d   = cnt_q - DT_W'(1);
          end else begin
            // Opposite side requested mid-dead-time: restart the full interval.
            target_d = req;
            cnt_d    = DT_RELOAD;
          end
        end
        ST_P_ON: begin
          if (req == REQ_N) begin
            state_d  = ST_DEAD;
            target_d = REQ_N;
            cnt_d    = DT_RELOAD;
          end else if (req == REQ_NONE) begin
            state_d  = ST_OFF;
            target_d = REQ_NONE;
          end
        end
        ST_N_ON: begin
          if (req == REQ_P) begin
            state_d  = ST_DEAD;
            target_d = REQ_P;
            cnt_d    = DT_RELOAD;
          end else if (req == REQ_NONE) begin
            state_d  = ST_OFF;
            target_d = REQ_NONE;
          end
        end
        default: begin
          state_d  = ST_OFF;
          target_d = REQ_NONE;
          cnt_d    = '0;
        end
      endcase
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      target_q <= REQ_NONE;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      gp_q     <= 1'b0;
      gn_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      // NOTE: gates decode the next state so the registered pins change on the same edge as the FSM.
      gp_q     <= (state_d == ST_P_ON);
      gn_q     <= (state_d == ST_N_ON);
    end
  end

  assign leg.gp = gp_q;
  assign leg.gn = gn_q;
  assign fault  = fault_q;

endmodule

// File: rtl/rectifier_deadtime.sv
// Top of the rectifier dead-time stage: fans SD/reset out to three dt_leg
// controllers and maps the pin-level switch/gate names. Option: RECT_DT_FAULT_LATCH_EN.
module rectifier_deadtime
  import rect_pkg::*;
#(
  parameter int DT_CYCLES = RECT_DT_DEFAULT,
  parameter int DT_W      = 8
) (
  input  logic       sysclk,
  input  logic       global_rst,
  input  logic       SD,
  input  logic       Sap,
  input  logic       San,
  input  logic       Sbp,
  input  logic       Sbn,
  input  logic       Scp,
  input  logic       Scn,
  input  logic       fault_clr,
  output logic       Gap,
  output logic       Gan,
  output logic       Gbp,
  output logic       Gbn,
  output logic       Gcp,
  output logic       Gcn,
  output logic [2:0] fault
);

  rectifier_deadtime_if leg_a ();
  rectifier_deadtime_if leg_b ();
  rectifier_deadtime_if leg_c ();

  assign leg_a.p = Sap;
  assign leg_a.n = San;
  assign leg_b.p = Sbp;
  assign leg_b.n = Sbn;
  assign leg_c.p = Scp;
  assign leg_c.n = Scn;

  assign Gap = leg_a.gp;
  assign Gan = leg_a.gn;
  assign Gbp = leg_b.gp;
  assign Gbn = leg_b.gn;
  assign Gcp = leg_c.gp;
  assign Gcn = leg_c.gn;

  dt_leg #(.DT_CYCLES(DT_CYCLES), .DT_W(DT_W)) u_leg_a (
    .clk(sysclk), .rst_n(global_rst), .sd(SD), .fault_clr(fault_clr),
    .leg(leg_a), .fault(fault[0])
  );

  dt_leg #(.DT_CYCLES(DT_CYCLES), .DT_W(DT_W)) u_leg_b (
    .clk(sysclk), .rst_n(global_rst), .sd(SD), .fault_clr(fault_clr),
    .leg(leg_b), .fault(fault[1])
  );

  dt_leg #(.DT_CYCLES(DT_CYCLES), .DT_W(DT_W)) u_leg_c (
    .clk(sysclk), .rst_n(global_rst), .sd(SD), .fault_clr(fault_clr),
    .leg(leg_c), .fault(fault[2])
  );

endmodule

// File: tb/tb_rectifier_deadtime.sv
// Directed bench for rectifier_deadtime: per-cycle vector table on a DT=4 build,
// plus hand sequences for DT=1 turn-on, SD during a DT=10 dead time and BOTH requests.
module tb_rectifier_deadtime;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sd;
  logic fault_clr;

  rectifier_deadtime_if leg_a ();
  rectifier_deadtime_if leg_b ();
  rectifier_deadtime_if leg_c ();

  logic [2:0] fault4;
  wire  [2:0] fault10;
  wire  [2:0] fault1;
  wire  [5:0] g10;
  wire  [5:0] g1;
  logic [5:0] g4;

  assign g4 = {leg_a.gp, leg_a.gn, leg_b.gp, leg_b.gn, leg_c.gp, leg_c.gn};

  rectifier_deadtime #(.DT_CYCLES(4), .DT_W(8)) dut4 (
    .sysclk(clk), .global_rst(rst_n), .SD(sd),
    .Sap(leg_a.p), .San(leg_a.n), .Sbp(leg_b.p), .Sbn(leg_b.n), .Scp(leg_c.p), .Scn(leg_c.n),
    .fault_clr(fault_clr),
    .Gap(leg_a.gp), .Gan(leg_a.gn), .Gbp(leg_b.gp), .Gbn(leg_b.gn), .Gcp(leg_c.gp), .Gcn(leg_c.gn),
    .fault(fault4)
  );

  rectifier_deadtime #(.DT_CYCLES(10), .DT_W(8)) dut10 (
    .sysclk(clk), .global_rst(rst_n), .SD(sd),
    .Sap(leg_a.p), .San(leg_a.n), .Sbp(leg_b.p), .Sbn(leg_b.n), .Scp(leg_c.p), .Scn(leg_c.n),
    .fault_clr(fault_clr),
    .Gap(g10[5]), .Gan(g10[4]), .Gbp(g10[3]), .Gbn(g10[2]), .Gcp(g10[1]), .Gcn(g10[0]),
    .fault(fault10)
  );

  rectifier_deadtime #(.DT_CYCLES(1), .DT_W(8)) dut1 (
    .sysclk(clk), .global_rst(rst_n), .SD(sd),
    .Sap(leg_a.p), .San(leg_a.n), .Sbp(leg_b.p), .Sbn(leg_b.n), .Scp(leg_c.p), .Scn(leg_c.n),
    .fault_clr(fault_clr),
    .Gap(g1[5]), .Gan(g1[4]), .Gbp(g1[3]), .Gbn(g1[2]), .Gcp(g1[1]), .Gcn(g1[0]),
    .fault(fault1)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       sd;
    logic [5:0] s;   // {Sap, San, Sbp, Sbn, Scp, Scn}
    logic [5:0] g;   // expected {Gap, Gan, Gbp, Gbn, Gcp, Gcn} after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_s(input logic [5:0] s);
    leg_a.p = s[5]; leg_a.n = s[4];
    leg_b.p = s[3]; leg_b.n = s[2];
    leg_c.p = s[1]; leg_c.n = s[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("no_overlap", {5'b0, leg_a.gp & leg_a.gn, leg_b.gp & leg_b.gn, leg_c.gp & leg_c.gn}, 8'h00);
  endtask

  task automatic add(input int n, input logic sdv, input logic [5:0] s, input logic [5:0] g);
    vec_t v;
    v.sd = sdv; v.s = s; v.g = g;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  logic [5:0] bs[15];
  logic       bc[15];
  logic [2:0] bf[15];
  logic       bg[15];

  initial begin
    // Turn-on from reset release, commutation, turn-off.
    add(4, 1, 6'b100000, 6'b000000);
    add(2, 1, 6'b100000, 6'b100000);
    add(4, 1, 6'b010000, 6'b000000);
    add(1, 1, 6'b010000, 6'b010000);
    add(1, 1, 6'b000000, 6'b000000);
    // Three-cycle glitch on leg b, then exactly DT cycles.
    add(3, 1, 6'b001000, 6'b000000);
    add(2, 1, 6'b000000, 6'b000000);
    add(4, 1, 6'b001000, 6'b000000);
    add(1, 1, 6'b001000, 6'b001000);
    // Staggered activity across legs.
    add(4, 1, 6'b001001, 6'b001000);
    add(1, 1, 6'b001001, 6'b001001);
    add(1, 1, 6'b101001, 6'b001001);
    add(3, 1, 6'b100101, 6'b000001);
    add(1, 1, 6'b100101, 6'b100001);
    add(1, 1, 6'b100101, 6'b100101);
    add(1, 1, 6'b000000, 6'b000000);
    // Retarget inside DEAD reloads the counter.
    add(2, 1, 6'b000010, 6'b000000);
    add(4, 1, 6'b000001, 6'b000000);
    add(1, 1, 6'b000001, 6'b000001);
    // SD low from N_ON, then full dead time again.
    add(1, 0, 6'b000001, 6'b000000);
    add(4, 1, 6'b000001, 6'b000000);
    add(1, 1, 6'b000001, 6'b000001);
    add(1, 1, 6'b000000, 6'b000000);

    for (int b = 0; b < 15; b++) begin
      bs[b] = (b < 2 || b == 3) ? 6'b000011 : 6'b000010;
      bc[b] = (b == 3 || b == 9);
`ifdef RECT_DT_FAULT_LATCH_EN
      bf[b] = (b <= 8) ? 3'b100 : 3'b000;
      bg[b] = (b == 14);
`else
      bf[b] = (b < 2 || b == 3) ? 3'b100 : 3'b000;
      bg[b] = (b >= 8);
`endif
    end

    // Reset held with a live request.
    rst_n = 1'b0; sd = 1'b1; fault_clr = 1'b0;
    set_s(6'b100000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gates", {2'b0, g4}, 8'h00);
      check("rst_fault", {5'b0, fault4}, 8'h00);
    end
    check("rst_gates_dt10", {2'b0, g10}, 8'h00);

    rst_n = 1'b1;
    foreach (vecs[i]) begin
      sd = vecs[i].sd;
      set_s(vecs[i].s);
      tick();
      check($sformatf("vec%0d_gates", i), {2'b0, g4}, {2'b0, vecs[i].g});
      check($sformatf("vec%0d_fault", i), {5'b0, fault4}, 8'h00);
    end

    // DT=1: gate high one edge after the first sample.
    set_s(6'b100000);
    tick();
    check("dt1_dead", {2'b0, g1}, 8'h00);
    tick();
    check("dt1_on", {2'b0, g1}, 8'h20);
    set_s(6'b000000);
    tick();
    check("dt1_off", {2'b0, g1}, 8'h00);

    // SD low at cycle 5 of a 10-cycle dead time on leg c.
    set_s(6'b000010);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dt10_dead", {2'b0, g10}, 8'h00);
    end
    sd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dt10_sd_gates", {2'b0, g10}, 8'h00);
      check("dt10_sd_fault", {5'b0, fault10}, 8'h00);
    end
    sd = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      check($sformatf("dt10_resume%0d", i), {7'b0, g10[1]}, {7'b0, (i == 10)});
    end
    check("dt10_others", {2'b0, g10 & 6'b111101}, 8'h00);

    // BOTH request on leg c, fault_clr alongside BOTH, then clear.
    set_s(6'b000000);
    tick();
    check("both_pre", {2'b0, g4}, 8'h00);
    for (int b = 0; b < 15; b++) begin
      set_s(bs[b]);
      fault_clr = bc[b];
      tick();
      check($sformatf("both%0d_fault", b), {5'b0, fault4}, {5'b0, bf[b]});
      check($sformatf("both%0d_gates", b), {2'b0, g4}, {6'b0, bg[b], 1'b0});
    end
    fault_clr = 1'b0;
    check("both_dt1_fault", {5'b0, fault1}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
